// File: rtl/reg_file_n_if.sv
// Read/write/claim bundle for reg_file_n; master drives selects and data, slave returns read data and busy flags.
// Interface only; it holds no state and applies no backpressure.
interface reg_file_n_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] dest_sel;
  logic [WIDTH-1:0]  d;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_sel;
  logic [ADDR_W-1:0] a_sel;
  logic [ADDR_W-1:0] b_sel;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              a_busy;
  logic              b_busy;

  modport master (
    output load_en, dest_sel, d, claim_en, claim_sel, a_sel, b_sel,
    input  A, B, a_busy, b_busy
  );

  modport slave (
    input  load_en, dest_sel, d, claim_en, claim_sel, a_sel, b_sel,
    output A, B, a_busy, b_busy
  );
endinterface

// File: rtl/reg_file_n.sv
// Register file with a per-register busy scoreboard; A/B/a_busy/b_busy are registered (1-cycle latency) with write/claim bypass.
// No backpressure: every write and claim is accepted. Define REG_FILE_N_ZERO_R0_EN to hardwire register 0 to zero and never busy.
module reg_file_n #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  reg_file_n_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic             wr_ok;
  logic             claim_ok;
  logic             wr_hit_a;
  logic             wr_hit_b;
  logic             cl_hit_a;
  logic             cl_hit_b;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             a_busy_nxt;
  logic             b_busy_nxt;

  // With the zero-r0 option, index 0 writes/claims are dropped before they
  // reach storage or bypass, so r0 stays at its reset value of zero.
`ifdef REG_FILE_N_ZERO_R0_EN
  assign wr_ok    = rf.load_en  && (rf.dest_sel  != '0);
  assign claim_ok = rf.claim_en && (rf.claim_sel != '0);
`else
  assign wr_ok    = rf.load_en;
  assign claim_ok = rf.claim_en;
`endif

  always_comb begin
    wr_hit_a   = wr_ok    && (rf.dest_sel  == rf.a_sel);
    wr_hit_b   = wr_ok    && (rf.dest_sel  == rf.b_sel);
    cl_hit_a   = claim_ok && (rf.claim_sel == rf.a_sel);
    cl_hit_b   = claim_ok && (rf.claim_sel == rf.b_sel);
    a_nxt      = wr_hit_a ? rf.d : regs[rf.a_sel];
    b_nxt      = wr_hit_b ? rf.d : regs[rf.b_sel];
    // Claim beats a same-cycle write to the same register.
    a_busy_nxt = cl_hit_a | (~wr_hit_a & busy[rf.a_sel]);
    b_busy_nxt = cl_hit_b | (~wr_hit_b & busy[rf.b_sel]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy      <= '0;
      rf.A      <= '0;
      rf.B      <= '0;
      rf.a_busy <= 1'b0;
      rf.b_busy <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[rf.dest_sel] <= rf.d;
        busy[rf.dest_sel] <= 1'b0;
      end
      if (claim_ok) begin
        busy[rf.claim_sel] <= 1'b1;
      end
      rf.A      <= a_nxt;
      rf.B      <= b_nxt;
      rf.a_busy <= a_busy_nxt;
      rf.b_busy <= b_busy_nxt;
    end
  end
endmodule
